// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse element encoding, FSM states, gap thresholds and code-to-ASCII lookup
package morse_pkg;

   localparam logic DOT  = 1'b0;
   localparam logic DASH = 1'b1;

   localparam int CODE_W         = 7;
   localparam int DASH_UNITS     = 2;
   localparam int CHAR_GAP_UNITS = 2;
   localparam int WORD_GAP_UNITS = 5;

   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

   typedef enum logic [1:0] {IDLE, MARK, GAP, WORD_WAIT} state_t;

   function automatic logic [7:0] morse_lookup(input logic [CODE_W-1:0] code);
      morse_lookup = ASCII_UNKNOWN;
      case (code)
         7'd2:  morse_lookup = "E";
         7'd3:  morse_lookup = "T";
         7'd4:  morse_lookup = "I";
         7'd5:  morse_lookup = "A";
         7'd6:  morse_lookup = "N";
         7'd7:  morse_lookup = "M";
         7'd8:  morse_lookup = "S";
         7'd9:  morse_lookup = "U";
         7'd10: morse_lookup = "R";
         7'd11: morse_lookup = "W";
         7'd12: morse_lookup = "D";
         7'd13: morse_lookup = "K";
         7'd14: morse_lookup = "G";
         7'd15: morse_lookup = "O";
         7'd16: morse_lookup = "H";
         7'd17: morse_lookup = "V";
         7'd18: morse_lookup = "F";
         7'd20: morse_lookup = "L";
         7'd22: morse_lookup = "P";
         7'd23: morse_lookup = "J";
         7'd24: morse_lookup = "B";
         7'd25: morse_lookup = "X";
         7'd26: morse_lookup = "C";
         7'd27: morse_lookup = "Y";
         7'd28: morse_lookup = "Z";
         7'd29: morse_lookup = "Q";
         7'd32: morse_lookup = "5";
         7'd33: morse_lookup = "4";
         7'd35: morse_lookup = "3";
         7'd39: morse_lookup = "2";
         7'd47: morse_lookup = "1";
         7'd48: morse_lookup = "6";
         7'd56: morse_lookup = "7";
         7'd60: morse_lookup = "8";
         7'd62: morse_lookup = "9";
         7'd63: morse_lookup = "0";
         default: morse_lookup = ASCII_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// morse_char_fifo: small synchronous queue of decoded characters with drop-on-full overflow pulse
module morse_char_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic       o_empty,
   output logic [7:0] o_data,
   output logic       o_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   logic        r_overflow;
   logic        w_full;
   logic        w_pop;
   logic        w_wr;

   assign o_empty    = r_wr == r_rd;
   assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop      = i_pop & ~o_empty;
   assign w_wr       = i_push & (~w_full | w_pop);
   assign o_data     = o_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
   assign o_overflow = r_overflow;

   // storage: a pop on a full queue frees the head slot in the same cycle
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
   end

   // pointers and one-cycle overflow flag for pushes that found no room
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr       <= w_wr ? r_wr + 1'b1 : r_wr;
         r_rd       <= w_pop ? r_rd + 1'b1 : r_rd;
         r_overflow <= i_push & ~w_wr;
      end
   end

endmodule

// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder: debounces a keyed envelope, times marks/spaces in dot units and queues decoded ASCII
module morse_rx_decoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES     = 2160000,
   parameter int DEBOUNCE_CYCLES = 36000,
   parameter int MAX_ELEMENTS    = 6,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       key_in,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       overflow,
   output logic       busy,
   output logic       key_clean
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(UNIT_CYCLES + 1);
   localparam int CW = $clog2(MAX_ELEMENTS + 1);

   logic [1:0]        r_sync;
   logic              r_key_clean;
   logic [DW-1:0]     r_deb_cnt;
   logic [PW-1:0]     r_pre;
   logic [3:0]        r_unit;
   state_t            r_state;
   state_t            w_next;
   logic [CODE_W-1:0] r_code;
   logic [CW-1:0]     r_cnt;
   logic              r_err;
   logic              r_space_armed;
   logic              w_toggle;
   logic              w_rise;
   logic              w_fall;
   logic              w_tick;
   logic              w_elem;
   logic              w_append;
   logic              w_emit_char;
   logic              w_emit_space;
   logic              w_push;
   logic [7:0]        w_push_data;
   logic              w_empty;

   assign w_toggle    = (r_sync[1] != r_key_clean) && (r_deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
   assign w_rise      = w_toggle & ~r_key_clean;
   assign w_fall      = w_toggle & r_key_clean;
   assign w_tick      = r_pre == PW'(UNIT_CYCLES - 1);
   assign w_elem      = (r_unit >= 4'(DASH_UNITS)) ? DASH : DOT;
   assign w_push      = w_emit_char | w_emit_space;
   assign w_push_data = w_emit_space ? ASCII_SPACE : (r_err ? ASCII_UNKNOWN : morse_lookup(r_code));
   assign key_clean   = r_key_clean;
   assign busy        = r_cnt != '0;
   assign char_valid  = ~w_empty;

   // synchronise the raw key and accept a new level only after it has held steadily
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_sync      <= 2'b00;
         r_key_clean <= 1'b0;
         r_deb_cnt   <= '0;
      end else begin
         r_sync      <= {r_sync[0], key_in};
         r_key_clean <= r_key_clean ^ w_toggle;
         r_deb_cnt   <= (r_sync[1] == r_key_clean || w_toggle) ? '0 : r_deb_cnt + 1'b1;
      end
   end

   // dot-unit timebase, restarted on every clean key edge so each mark/space is measured from zero
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_pre  <= '0;
         r_unit <= 4'd0;
      end else begin
         r_pre  <= (w_toggle || w_tick) ? '0 : r_pre + 1'b1;
         r_unit <= w_toggle ? 4'd0 : (w_tick && r_unit != 4'hF) ? r_unit + 4'd1 : r_unit;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // FSM transitions: classify marks on release, close characters and words on long spaces
   always_comb begin
      w_next       = r_state;
      w_append     = 1'b0;
      w_emit_char  = 1'b0;
      w_emit_space = 1'b0;
      case (r_state)
         IDLE: w_next = w_rise ? MARK : IDLE;
         MARK: begin
            w_append = w_fall;
            w_next   = w_fall ? GAP : MARK;
         end
         GAP: begin
            w_emit_char = ~w_rise && r_unit >= 4'(CHAR_GAP_UNITS);
            w_next      = w_rise ? MARK : w_emit_char ? WORD_WAIT : GAP;
         end
         WORD_WAIT: begin
            w_emit_space = ~w_rise && r_unit >= 4'(WORD_GAP_UNITS) && r_space_armed;
            w_next       = w_rise ? MARK : (r_unit >= 4'(WORD_GAP_UNITS)) ? IDLE : WORD_WAIT;
         end
         default: w_next = IDLE;
      endcase
   end

   // element assembly: sentinel-prefixed code, overlong characters flagged and later shown as '?'
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_code        <= CODE_W'(1);
         r_cnt         <= '0;
         r_err         <= 1'b0;
         r_space_armed <= 1'b0;
      end else if (w_emit_char) begin
         r_code        <= CODE_W'(1);
         r_cnt         <= '0;
         r_err         <= 1'b0;
         r_space_armed <= 1'b1;
      end else begin
         if (w_emit_space) r_space_armed <= 1'b0;
         if (w_append && r_cnt == CW'(MAX_ELEMENTS)) r_err <= 1'b1;
         else if (w_append) begin
            r_code <= {r_code[CODE_W-2:0], w_elem};
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

   morse_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .resetq     (resetq),
      .i_push     (w_push),
      .i_data     (w_push_data),
      .i_pop      (char_ready),
      .o_empty    (w_empty),
      .o_data     (char_data),
      .o_overflow (overflow)
   );

endmodule

// File: tb/tb_morse_rx_decoder.sv
// tb_morse_rx_decoder: directed keying sequences with hand-computed decoded characters
module tb_morse_rx_decoder;

   logic       clk = 1'b0;
   logic       resetq = 1'b0;
   logic       key_in = 1'b0;
   logic       char_ready = 1'b0;
   logic [7:0] char_data;
   logic       char_valid;
   logic       overflow;
   logic       busy;
   logic       key_clean;
   int         checks = 0;
   int         errors = 0;
   int         ovf_cnt = 0;
   int         ovf_base = 0;

   morse_rx_decoder #(
      .UNIT_CYCLES     (4),
      .DEBOUNCE_CYCLES (2),
      .MAX_ELEMENTS    (6),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk        (clk),
      .resetq     (resetq),
      .key_in     (key_in),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .overflow   (overflow),
      .busy       (busy),
      .key_clean  (key_clean)
   );

   always #5 clk = ~clk;

   // count overflow pulses as they happen
   always @(posedge clk) begin
      if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
   end

   task automatic chk(input logic [7:0] got, input logic [7:0] exp, input string tag);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic key(input logic lvl, input int cyc);
      key_in = lvl;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic pop_expect(input logic [7:0] exp, input string tag);
      int n = 0;
      while (char_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(8'(char_valid), 8'h01, {tag, "_valid"});
      chk(char_data, exp, tag);
      char_ready = 1'b1;
      @(negedge clk);
      char_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk(8'(char_valid), 8'h00, "rst_valid");
      chk(char_data, 8'h00, "rst_data");
      chk(8'(busy), 8'h00, "rst_busy");
      chk(8'(key_clean), 8'h00, "rst_key");
      chk(8'(overflow), 8'h00, "rst_ovf");
      resetq = 1'b1;
      repeat (4) @(negedge clk);
      // 'A' = dot, dash
      chk(8'(busy), 8'h00, "a_busy_pre");
      key(1, 4);
      key(0, 4);
      chk(8'(busy), 8'h01, "a_busy_gap");
      key(1, 12);
      chk(8'(busy), 8'h01, "a_busy_mark");
      key(0, 16);
      chk(8'(busy), 8'h00, "a_busy_emit");
      pop_expect(8'h41, "a_char");
      key(0, 40);
      pop_expect(8'h20, "a_space");
      chk(8'(char_valid), 8'h00, "a_one_space");
      // 'S' word gap 'O'
      key(1, 4); key(0, 4); key(1, 4); key(0, 4); key(1, 4); key(0, 28);
      key(1, 12); key(0, 4); key(1, 12); key(0, 4); key(1, 12); key(0, 40);
      pop_expect(8'h53, "so_s");
      pop_expect(8'h20, "so_space");
      pop_expect(8'h4F, "so_o");
      pop_expect(8'h20, "so_tail");
      chk(8'(char_valid), 8'h00, "so_empty");
      chk(8'(ovf_cnt), 8'h00, "so_no_ovf");
      // seven dots overflow the element register
      repeat (7) begin
         key(1, 4);
         key(0, 4);
      end
      key(0, 36);
      pop_expect(8'h3F, "err_char");
      pop_expect(8'h20, "err_space");
      key(1, 12);
      key(0, 40);
      pop_expect(8'h54, "err_next_t");
      pop_expect(8'h20, "err_next_space");
      chk(8'(char_valid), 8'h00, "err_empty");
      // single-cycle glitches are rejected
      repeat (3) begin
         key(1, 1);
         key(0, 6);
         chk(8'(key_clean), 8'h00, "glitch_key");
      end
      chk(8'(busy), 8'h00, "glitch_busy");
      chk(8'(char_valid), 8'h00, "glitch_valid");
      // five 'E' into a four-deep queue
      ovf_base = ovf_cnt;
      repeat (4) begin
         key(1, 4);
         key(0, 12);
      end
      key(1, 4);
      key(0, 16);
      chk(8'(ovf_cnt - ovf_base), 8'h01, "ovf_once");
      pop_expect(8'h45, "ovf_e0");
      pop_expect(8'h45, "ovf_e1");
      pop_expect(8'h45, "ovf_e2");
      pop_expect(8'h45, "ovf_e3");
      key(0, 40);
      pop_expect(8'h20, "ovf_space");
      chk(8'(char_valid), 8'h00, "ovf_empty");
      chk(8'(ovf_cnt - ovf_base), 8'h01, "ovf_total");
      // reset mid-dash with two characters queued
      key(1, 4); key(0, 12); key(1, 4); key(0, 12);
      key(1, 4); key(0, 4); key(1, 8);
      chk(8'(busy), 8'h01, "rst_mid_busy");
      chk(8'(char_valid), 8'h01, "rst_mid_valid");
      resetq = 1'b0;
      #1;
      chk(8'(char_valid), 8'h00, "rst_async_valid");
      chk(8'(busy), 8'h00, "rst_async_busy");
      chk(char_data, 8'h00, "rst_async_data");
      chk(8'(key_clean), 8'h00, "rst_async_key");
      key_in = 1'b0;
      repeat (2) @(negedge clk);
      resetq = 1'b1;
      key(0, 40);
      chk(8'(char_valid), 8'h00, "rst_no_partial");
      key(1, 12);
      key(0, 16);
      pop_expect(8'h54, "rst_t");
      chk(8'(char_valid), 8'h00, "rst_t_only");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/morse_rx_decoder.md
Name: morse_rx_decoder

Overview:
Receive-side counterpart of the 2 m Morse keyer. Samples an on-off keyed envelope from a PMOD pin (key high = carrier present) and measures mark/space lengths in dot units. Classifies elements, assembles characters, and queues decoded ASCII for the SPI response path to read back.

Parameters:
UNIT_CYCLES, 2160000, clk cycles per dot unit (60 ms at 36 MHz, 20 WPM)
DEBOUNCE_CYCLES, 36000, clk cycles key_in must be stable before a level change is accepted (1 ms)
MAX_ELEMENTS, 6, maximum dots/dashes per character
FIFO_DEPTH, 4, decoded-character queue depth (power of two)

Ports:
clk  input  1  system clock (36 MHz PLL output)
resetq  input  1  asynchronous active-low reset
key_in  input  1  raw keyed envelope, asynchronous to clk
char_data  output  8  ASCII character at FIFO head
char_valid  output  1  FIFO not empty
char_ready  input  1  consumer pops head when char_valid && char_ready
overflow  output  1  one-cycle pulse: character dropped because FIFO full
busy  output  1  high while a character is being assembled (elements pending)
key_clean  output  1  synchronised, debounced key level

Behaviour:
- Reset: all outputs 0; FSM IDLE; element count 0; FIFO empty; space_armed 0.
- Input: 2-FF synchroniser, then debounce counter; key_clean toggles once synced input has differed from key_clean for DEBOUNCE_CYCLES consecutive cycles; any intermediate bounce restarts the count.
- Timing: prescaler 0..UNIT_CYCLES-1 emits unit_tick on wrap; unit_cnt (4 bits) increments per tick, saturates at 15. Both clear on every key_clean edge.
- FSM states: IDLE, MARK, GAP, WORD_WAIT.
  IDLE: key_clean rise -> MARK.
  MARK: key_clean fall -> append element (unit_cnt < 2 => dot=0, else dash=1) -> GAP.
  GAP: key_clean rise -> MARK; unit_cnt reaches 2 -> emit character, set space_armed -> WORD_WAIT.
  WORD_WAIT: unit_cnt reaches 5 -> emit 0x20, clear space_armed -> IDLE; key_clean rise -> MARK (no space).
- Element register: code = leading-1 sentinel followed by elements, MSB first (A ".-" = 3'b101). Appending beyond MAX_ELEMENTS sets err flag; elements discarded.
- Lookup (combinational from code): A-Z, 0-9 per ITU; unmapped code or err -> 0x3F '?'. Code register and err cleared on emit.
- Space: at most one 0x20 per gap; never before the first character after reset.
- FIFO: push on emit; pop on char_valid && char_ready. Push to a full FIFO: character dropped, overflow pulses, contents unchanged. Simultaneous push/pop when full: pop then push, no overflow. char_data valid while char_valid high, zero-latency from head.
- busy = element count != 0.
- Reset asserted mid-character or mid-FIFO: everything returns to reset values immediately; no partial character emitted afterwards.

Decomposition:
- Package morse_pkg: element encoding constants (DOT, DASH), FSM state enum, thresholds DASH_UNITS=2, CHAR_GAP_UNITS=2, WORD_GAP_UNITS=5, ASCII_SPACE, ASCII_UNKNOWN, code-to-ASCII lookup function.
- Sub-module morse_char_fifo: synchronous FIFO (8-bit, FIFO_DEPTH, clk/resetq, push/full/pop/empty). Debounce and timing stay inline.

Test Plan:
(all with UNIT_CYCLES=4, DEBOUNCE_CYCLES=2)
- Key ".-" (mark 1 unit, gap 1, mark 3), then release 3 units -> one pop yields 0x41 'A'; busy high from first mark to emit.
- "..." gap 7 units "---" -> FIFO yields 0x53, 0x20, 0x4F; exactly one 0x20.
- Seven dots in one character -> 0x3F emitted; next character decodes normally.
- 1-cycle glitches on key_in during idle -> key_clean stays 0, no elements, FIFO empty.
- char_ready=0, send 5 'E' characters -> first 4 queued, overflow pulses once on the fifth; popping yields four 0x45.
- Assert resetq low mid-dash with 2 chars queued -> char_valid=0, busy=0 immediately; after release, a full 'T' decodes as 0x54 only.
